idu_alu_iq: RTL and testbench
=============================

// Module: idu_alu_iq
// PURPOSE
//  ALU issue queue between rename/dispatch and exu_alu. Holds up to DEPTH dispatched ALU
//  instructions, captures not-yet-ready source operands from the ALU writeback broadcast,
//  and issues the oldest ready entry to exu_alu, at most one per cycle. Invalidated on rtu_global_flush.
// PARAMETERS
//  DEPTH   8   entry count, power of two, >=2
//  IID_W   5   ROB instruction id width
//  PREG_W  6   physical register tag width
//  XLEN    64  operand/data width
// PORTS
//  clk                      in   1       clock
//  rst_clk                  in   1       asynchronous reset, active-low
//  rtu_global_flush         in   1       drop all entries
//  dis_vld                  in   1       dispatch request
//  dis_rdy                  out  1       queue can accept (count < DEPTH)
//  dis_iid                  in   IID_W   ROB id
//  dis_opcode/funct7/funct3 in   7/7/3   decoded fields
//  dis_pc                   in   XLEN    instruction pc
//  dis_psrcN_vld            in   1       source N used (N=1,2)
//  dis_psrcN_rdy            in   1       source N value valid at dispatch
//  dis_psrcN_preg           in   PREG_W  source N physical tag
//  dis_psrcN_value          in   XLEN    source N value (meaningful when rdy)
//  dis_pdst_vld/dis_pdst    in   1/PREG_W destination
//  dis_imm_vld/dis_imm      in   1/XLEN  immediate
//  wb_vld/wb_preg/wb_data   in   1/PREG_W/XLEN  ALU writeback broadcast (exu_idu_rf_alu_wb_*)
//  idu_exu_alu_*            out  -       issue bundle to exu_alu: vld,iid,opcode,funct7,funct3,pc,
//                                        psrc1_vld/value,psrc2_vld/value,pdst_vld/pdst,imm_vld/imm
// BEHAVIOUR
//  Reset: all entries invalid, count=0; dis_rdy=1; idu_exu_alu_vld=0, all issue fields 0.
//  Storage: collapsing queue; slot 0 = oldest. Entry = valid, all dispatch fields, per-source rdy.
//  Source ready = ~psrcN_vld | psrcN_rdy. Entry ready = valid & src1 ready & src2 ready.
//  Wakeup: each cycle, every valid entry with psrcN_vld & ~rdy & preg==wb_preg & wb_vld
//   captures wb_data and sets rdy at the edge. Same for an entry being enqueued this cycle
//   (dispatch/wakeup same-cycle race must not lose the value).
//  Select: lowest-index ready entry; idu_exu_alu_vld = any ready & ~rtu_global_flush; fields
//   driven combinationally from that slot, zero when vld=0. Issued entry removed at the edge.
//  Latency: dispatch in cycle N -> earliest issue N+1. Dependent op: producer issued N, exu_alu
//   wb in N+1, consumer captures at end of N+1, issues N+2.
//  Enqueue: accepted when dis_vld & dis_rdy & ~flush; written at slot count (or count-1 when an
//   issue happens the same cycle). dis_rdy based on count at start of cycle (no issue credit).
//  Collapse: entries above the issued slot shift down one; shifted entries still take wakeup.
//  Count: +1 enqueue, -1 issue, both -> unchanged; never exceeds DEPTH.
//  Full: count==DEPTH -> dis_rdy=0; dis_vld while full is ignored (dispatcher must stall).
//  Empty: no issue; dispatch with both sources ready issues next cycle.
//  Flush: has priority; all valid cleared, count=0 at the edge; issue vld=0 and dispatch
//   ignored in the flush cycle; wakeup ignored.
//  Reset mid-operation: immediate clear, outputs to reset values asynchronously.
//  wb for a tag not held by any entry: no effect. Sources with psrcN_vld=0 never wake.
// STRUCTURE
//  Shared package: XLEN, IID_W, PREG_W, ALU opcode constants (R_ALU64, R_ALU32, I_ALU64,
//   I_ALU32, U_AUIPC, U_LUI), issue-bundle field widths.
//  Sub-module idu_alu_iq_entry: one slot's registers, wakeup compare/capture, shift-in mux,
//   ready output; top holds count, select priority encoder, enqueue/collapse control.
// TESTING
//  1 dispatch ADD iid=3, both srcs rdy (5,7) at N -> issue N+1: vld=1,iid=3,psrc1=5,psrc2=7; empty after.
//  2 dispatch A(pdst=12), then B(psrc1_preg=12,rdy=0); exu_alu wb 12=0x2A -> B issues 1 cycle after wb with psrc1=0x2A.
//  3 fill 8 non-ready entries -> dis_rdy=0 on 9th; wake slot 5 -> issues, next cycle dis_rdy=1, order preserved.
//  4 slots 0 and 2 woken same cycle -> slot 0 issues first, slot 2 (now slot 1) next cycle.
//  5 dispatch with psrc2 tag 9 not ready while wb_preg=9 same cycle -> entry enqueued ready, issues N+1.
//  6 4 entries, flush asserted with dis_vld=1 -> no issue that cycle, count=0 next, dis_rdy=1.

Source files
------------

// File: rtl/idu_alu_iq_pkg.sv
// Shared definitions for the ALU issue queue: default widths, issue-bundle
// field widths, ALU major opcodes and the source-ready helper.
package idu_alu_iq_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int XLEN     = 64;
  localparam int IID_W    = 5;
  localparam int PREG_W   = 6;

  // issue-bundle field widths
  localparam int OPC_W    = 7;
  localparam int F7_W     = 7;
  localparam int F3_W     = 3;

  // ALU major opcodes routed to this queue
  localparam logic [OPC_W-1:0] R_ALU64 = 7'b0110011;
  localparam logic [OPC_W-1:0] R_ALU32 = 7'b0111011;
  localparam logic [OPC_W-1:0] I_ALU64 = 7'b0010011;
  localparam logic [OPC_W-1:0] I_ALU32 = 7'b0011011;
  localparam logic [OPC_W-1:0] U_AUIPC = 7'b0010111;
  localparam logic [OPC_W-1:0] U_LUI   = 7'b0110111;

  // an unused source never blocks; a used one needs its value captured
  function automatic logic src_ready(input logic vld, input logic rdy);
    return ~vld | rdy;
  endfunction

endpackage

// File: rtl/idu_alu_iq_entry.sv
// One issue-queue slot. Entry vector layout (MSB first):
//   {valid, payload, src1, src2}, each src = {vld, rdy, preg, value}.
// The slot picks its next content (hold / shift from the slot above /
// dispatch), then applies writeback wakeup to whatever it ends up holding,
// so a value broadcast in the same cycle as a shift or enqueue is kept.
module idu_alu_iq_entry #(
  parameter  int PREG_W = idu_alu_iq_pkg::PREG_W,
  parameter  int XLEN   = idu_alu_iq_pkg::XLEN,
  parameter  int PAY_W  = 8,
  localparam int SRC_W  = 2 + PREG_W + XLEN,
  localparam int ENT_W  = 1 + PAY_W + 2 * SRC_W
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              flush,
  input  logic              wb_vld,
  input  logic [PREG_W-1:0] wb_preg,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ld_dis,
  input  logic              ld_shift,
  input  logic [ENT_W-1:0]  dis_ent,
  input  logic [ENT_W-1:0]  nb_ent,
  output logic [ENT_W-1:0]  ent,
  output logic              rdy
);
  import idu_alu_iq_pkg::*;

  localparam int SB_RDY = XLEN + PREG_W;
  localparam int SB_VLD = XLEN + PREG_W + 1;

  logic [ENT_W-1:0] ent_q, ent_d, base;

  function automatic logic [SRC_W-1:0] wake(input logic [SRC_W-1:0] s,
                                            input logic              en,
                                            input logic [PREG_W-1:0] tag,
                                            input logic [XLEN-1:0]   data);
    logic [SRC_W-1:0] r;
    r = s;
    if (en && s[SB_VLD] && !s[SB_RDY] && (s[XLEN +: PREG_W] == tag)) begin
      r[SB_RDY]     = 1'b1;
      r[XLEN-1:0]   = data;
    end
    return r;
  endfunction

  // next slot content: dispatch beats shift beats hold, then wakeup, flush clears
  always_comb begin
    base = ent_q;
    if (ld_dis)        base = dis_ent;
    else if (ld_shift) base = nb_ent;
    ent_d = base;
    ent_d[SRC_W +: SRC_W] = wake(base[SRC_W +: SRC_W], base[ENT_W-1] & wb_vld, wb_preg, wb_data);
    ent_d[0 +: SRC_W]     = wake(base[0 +: SRC_W],     base[ENT_W-1] & wb_vld, wb_preg, wb_data);
    if (flush) ent_d = '0;
  end

  // slot register
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) ent_q <= '0;
    else          ent_q <= ent_d;
  end

  assign ent = ent_q;
  assign rdy = ent_q[ENT_W-1]
             & src_ready(ent_q[SRC_W + SB_VLD], ent_q[SRC_W + SB_RDY])
             & src_ready(ent_q[SB_VLD],         ent_q[SB_RDY]);

endmodule

// File: rtl/idu_alu_iq.sv
// ALU issue queue: collapsing queue (slot 0 oldest) between dispatch and
// exu_alu. Issues the lowest-index ready slot each cycle; slots above it
// shift down one. New entries land at count, or count-1 when an issue
// frees a slot the same cycle.
module idu_alu_iq #(
  parameter int DEPTH  = idu_alu_iq_pkg::IQ_DEPTH,
  parameter int IID_W  = idu_alu_iq_pkg::IID_W,
  parameter int PREG_W = idu_alu_iq_pkg::PREG_W,
  parameter int XLEN   = idu_alu_iq_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              rtu_global_flush,
  input  logic              dis_vld,
  output logic              dis_rdy,
  input  logic [IID_W-1:0]  dis_iid,
  input  logic [6:0]        dis_opcode,
  input  logic [6:0]        dis_funct7,
  input  logic [2:0]        dis_funct3,
  input  logic [XLEN-1:0]   dis_pc,
  input  logic              dis_psrc1_vld,
  input  logic              dis_psrc1_rdy,
  input  logic [PREG_W-1:0] dis_psrc1_preg,
  input  logic [XLEN-1:0]   dis_psrc1_value,
  input  logic              dis_psrc2_vld,
  input  logic              dis_psrc2_rdy,
  input  logic [PREG_W-1:0] dis_psrc2_preg,
  input  logic [XLEN-1:0]   dis_psrc2_value,
  input  logic              dis_pdst_vld,
  input  logic [PREG_W-1:0] dis_pdst,
  input  logic              dis_imm_vld,
  input  logic [XLEN-1:0]   dis_imm,
  input  logic              wb_vld,
  input  logic [PREG_W-1:0] wb_preg,
  input  logic [XLEN-1:0]   wb_data,
  output logic              idu_exu_alu_vld,
  output logic [IID_W-1:0]  idu_exu_alu_iid,
  output logic [6:0]        idu_exu_alu_opcode,
  output logic [6:0]        idu_exu_alu_funct7,
  output logic [2:0]        idu_exu_alu_funct3,
  output logic [XLEN-1:0]   idu_exu_alu_pc,
  output logic              idu_exu_alu_psrc1_vld,
  output logic [XLEN-1:0]   idu_exu_alu_psrc1_value,
  output logic              idu_exu_alu_psrc2_vld,
  output logic [XLEN-1:0]   idu_exu_alu_psrc2_value,
  output logic              idu_exu_alu_pdst_vld,
  output logic [PREG_W-1:0] idu_exu_alu_pdst,
  output logic              idu_exu_alu_imm_vld,
  output logic [XLEN-1:0]   idu_exu_alu_imm
);
  import idu_alu_iq_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int SRC_W = 2 + PREG_W + XLEN;
  localparam int PAY_W = IID_W + OPC_W + F7_W + F3_W + XLEN + 1 + PREG_W + 1 + XLEN;
  localparam int ENT_W = 1 + PAY_W + 2 * SRC_W;

  logic [CNT_W-1:0]            count_q, count_d;
  logic [DEPTH-1:0][ENT_W-1:0] ent;
  logic [DEPTH-1:0]            rdy, ld_dis, ld_shift;
  logic [ENT_W-1:0]            dis_ent, sel_ent;
  logic [IDX_W-1:0]            iss_idx;
  logic [CNT_W-1:0]            enq_pos;
  logic                        iss, enq;

  // fields of the selected slot that exu_alu does not need
  logic              unused_sel_vld, unused_s1_rdy, unused_s2_rdy;
  logic [PREG_W-1:0] unused_s1_preg, unused_s2_preg;

  assign dis_ent = {1'b1, dis_iid, dis_opcode, dis_funct7, dis_funct3, dis_pc,
                    dis_pdst_vld, dis_pdst, dis_imm_vld, dis_imm,
                    dis_psrc1_vld, dis_psrc1_rdy, dis_psrc1_preg, dis_psrc1_value,
                    dis_psrc2_vld, dis_psrc2_rdy, dis_psrc2_preg, dis_psrc2_value};

  // occupancy at start of cycle only; an issue this cycle gives no credit
  assign dis_rdy = (count_q != CNT_W'(DEPTH));
  assign iss     = (|rdy) & ~rtu_global_flush;
  assign enq     = dis_vld & dis_rdy & ~rtu_global_flush;
  assign enq_pos = iss ? (count_q - CNT_W'(1)) : count_q;

  // oldest-first select: lowest ready index wins
  always_comb begin
    iss_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (rdy[i]) iss_idx = IDX_W'(i);
  end

  // per-slot load controls: collapse above the issued slot, enqueue at the tail
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ld_dis[i]   = enq && (enq_pos == CNT_W'(i));
      ld_shift[i] = iss && (IDX_W'(i) >= iss_idx);
    end
  end

  // occupancy update; flush wins
  always_comb begin
    count_d = count_q;
    if (rtu_global_flush)  count_d = '0;
    else if (enq && !iss)  count_d = count_q + CNT_W'(1);
    else if (!enq && iss)  count_d = count_q - CNT_W'(1);
  end

  // occupancy register
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) count_q <= '0;
    else          count_q <= count_d;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [ENT_W-1:0] nb_ent;
    if (g == DEPTH - 1) begin : g_last
      assign nb_ent = '0;
    end else begin : g_mid
      assign nb_ent = ent[g+1];
    end

    idu_alu_iq_entry #(
      .PREG_W (PREG_W),
      .XLEN   (XLEN),
      .PAY_W  (PAY_W)
    ) u_entry (
      .clk      (clk),
      .rst_clk  (rst_clk),
      .flush    (rtu_global_flush),
      .wb_vld   (wb_vld),
      .wb_preg  (wb_preg),
      .wb_data  (wb_data),
      .ld_dis   (ld_dis[g]),
      .ld_shift (ld_shift[g]),
      .dis_ent  (dis_ent),
      .nb_ent   (nb_ent),
      .ent      (ent[g]),
      .rdy      (rdy[g])
    );
  end

  // issue bundle is all-zero whenever nothing issues
  assign sel_ent         = iss ? ent[iss_idx] : '0;
  assign idu_exu_alu_vld = iss;
  assign {unused_sel_vld, idu_exu_alu_iid, idu_exu_alu_opcode, idu_exu_alu_funct7,
          idu_exu_alu_funct3, idu_exu_alu_pc, idu_exu_alu_pdst_vld, idu_exu_alu_pdst,
          idu_exu_alu_imm_vld, idu_exu_alu_imm,
          idu_exu_alu_psrc1_vld, unused_s1_rdy, unused_s1_preg, idu_exu_alu_psrc1_value,
          idu_exu_alu_psrc2_vld, unused_s2_rdy, unused_s2_preg, idu_exu_alu_psrc2_value} = sel_ent;

endmodule

// File: tb/tb_idu_alu_iq.sv
// Directed bench for idu_alu_iq: a table of single-instruction vectors
// (dispatch then issue next cycle), plus hand sequences for dependency
// wakeup, full queue, oldest-first ordering, flush and async reset.
module tb_idu_alu_iq;
  import idu_alu_iq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_clk;
  logic        rtu_global_flush;
  logic        dis_vld, dis_rdy;
  logic [4:0]  dis_iid;
  logic [6:0]  dis_opcode, dis_funct7;
  logic [2:0]  dis_funct3;
  logic [63:0] dis_pc;
  logic        dis_psrc1_vld, dis_psrc1_rdy, dis_psrc2_vld, dis_psrc2_rdy;
  logic [5:0]  dis_psrc1_preg, dis_psrc2_preg;
  logic [63:0] dis_psrc1_value, dis_psrc2_value;
  logic        dis_pdst_vld, dis_imm_vld;
  logic [5:0]  dis_pdst;
  logic [63:0] dis_imm;
  logic        wb_vld;
  logic [5:0]  wb_preg;
  logic [63:0] wb_data;
  logic        o_vld, o_s1v, o_s2v, o_pdv, o_imv;
  logic [4:0]  o_iid;
  logic [6:0]  o_opc, o_f7;
  logic [2:0]  o_f3;
  logic [63:0] o_pc, o_s1, o_s2, o_imm;
  logic [5:0]  o_pd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idu_alu_iq dut (
    .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(rtu_global_flush),
    .dis_vld(dis_vld), .dis_rdy(dis_rdy), .dis_iid(dis_iid),
    .dis_opcode(dis_opcode), .dis_funct7(dis_funct7), .dis_funct3(dis_funct3), .dis_pc(dis_pc),
    .dis_psrc1_vld(dis_psrc1_vld), .dis_psrc1_rdy(dis_psrc1_rdy),
    .dis_psrc1_preg(dis_psrc1_preg), .dis_psrc1_value(dis_psrc1_value),
    .dis_psrc2_vld(dis_psrc2_vld), .dis_psrc2_rdy(dis_psrc2_rdy),
    .dis_psrc2_preg(dis_psrc2_preg), .dis_psrc2_value(dis_psrc2_value),
    .dis_pdst_vld(dis_pdst_vld), .dis_pdst(dis_pdst), .dis_imm_vld(dis_imm_vld), .dis_imm(dis_imm),
    .wb_vld(wb_vld), .wb_preg(wb_preg), .wb_data(wb_data),
    .idu_exu_alu_vld(o_vld), .idu_exu_alu_iid(o_iid), .idu_exu_alu_opcode(o_opc),
    .idu_exu_alu_funct7(o_f7), .idu_exu_alu_funct3(o_f3), .idu_exu_alu_pc(o_pc),
    .idu_exu_alu_psrc1_vld(o_s1v), .idu_exu_alu_psrc1_value(o_s1),
    .idu_exu_alu_psrc2_vld(o_s2v), .idu_exu_alu_psrc2_value(o_s2),
    .idu_exu_alu_pdst_vld(o_pdv), .idu_exu_alu_pdst(o_pd),
    .idu_exu_alu_imm_vld(o_imv), .idu_exu_alu_imm(o_imm)
  );

  typedef struct {
    logic [4:0]  iid;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [63:0] pc;
    logic        s1v, s1r;
    logic [5:0]  s1p;
    logic [63:0] s1val;
    logic        s2v, s2r;
    logic [5:0]  s2p;
    logic [63:0] s2val;
    logic        pdv;
    logic [5:0]  pd;
    logic        imv;
    logic [63:0] imm;
    logic        wbv;
    logic [5:0]  wbp;
    logic [63:0] wbd;
    logic [63:0] exp_s1, exp_s2;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rtu_global_flush = 1'b0; dis_vld = 1'b0; dis_iid = '0;
    dis_opcode = '0; dis_funct7 = '0; dis_funct3 = '0; dis_pc = '0;
    dis_psrc1_vld = 1'b0; dis_psrc1_rdy = 1'b0; dis_psrc1_preg = '0; dis_psrc1_value = '0;
    dis_psrc2_vld = 1'b0; dis_psrc2_rdy = 1'b0; dis_psrc2_preg = '0; dis_psrc2_value = '0;
    dis_pdst_vld = 1'b0; dis_pdst = '0; dis_imm_vld = 1'b0; dis_imm = '0;
    wb_vld = 1'b0; wb_preg = '0; wb_data = '0;
  endtask

  task automatic disp(input logic [4:0] iid,
                      input logic s1v, input logic s1r, input logic [5:0] s1p, input logic [63:0] s1val,
                      input logic s2v, input logic s2r, input logic [5:0] s2p, input logic [63:0] s2val,
                      input logic [5:0] pd);
    dis_vld = 1'b1; dis_iid = iid; dis_opcode = R_ALU64; dis_pc = 64'h8000;
    dis_psrc1_vld = s1v; dis_psrc1_rdy = s1r; dis_psrc1_preg = s1p; dis_psrc1_value = s1val;
    dis_psrc2_vld = s2v; dis_psrc2_rdy = s2r; dis_psrc2_preg = s2p; dis_psrc2_value = s2val;
    dis_pdst_vld = 1'b1; dis_pdst = pd;
  endtask

  task automatic wb(input logic [5:0] p, input logic [63:0] d);
    wb_vld = 1'b1; wb_preg = p; wb_data = d;
  endtask

  // hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // iid opc f7 f3 pc | s1 v r p val | s2 v r p val | pdst | imm | wb v p d | exp s1 s2
    vt[0] = '{5'd3, R_ALU64, 7'h00, 3'd0, 64'h1000, 1'b1, 1'b1, 6'd1, 64'd5, 1'b1, 1'b1, 6'd2, 64'd7, 1'b1, 6'd10, 1'b0, 64'd0, 1'b0, 6'd0, 64'd0, 64'd5, 64'd7};
    vt[1] = '{5'd4, R_ALU32, 7'h20, 3'd0, 64'h2004, 1'b1, 1'b1, 6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 6'd4, 64'd1, 1'b1, 6'd11, 1'b0, 64'd0, 1'b0, 6'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    // unused src2 whose tag matches the broadcast keeps its dispatch value
    vt[2] = '{5'd7, I_ALU64, 7'h00, 3'd0, 64'h3000, 1'b1, 1'b1, 6'd5, 64'h100, 1'b0, 1'b0, 6'd9, 64'hAB, 1'b1, 6'd14, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 6'd9, 64'hEE, 64'h100, 64'hAB};
    // dispatch/wakeup race: src2 tag 9 broadcast in the dispatch cycle
    vt[3] = '{5'd8, R_ALU64, 7'h00, 3'd7, 64'h4000, 1'b1, 1'b1, 6'd6, 64'h11, 1'b1, 1'b0, 6'd9, 64'd0, 1'b1, 6'd15, 1'b0, 64'd0, 1'b1, 6'd9, 64'h99, 64'h11, 64'h99};
    vt[4] = '{5'd31, U_LUI, 7'h00, 3'd0, 64'h5000, 1'b0, 1'b0, 6'd3, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd16, 1'b1, 64'h12345000, 1'b1, 6'd3, 64'h5, 64'd0, 64'd0};
    // already-ready source is not overwritten by a matching broadcast
    vt[5] = '{5'd0, U_AUIPC, 7'h00, 3'd0, 64'h6000, 1'b1, 1'b1, 6'd9, 64'd5, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd17, 1'b1, 64'h1000, 1'b1, 6'd9, 64'hEE, 64'd5, 64'd0};

    idle();
    rst_clk = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_vld", o_vld, 1'b0);
    chk("rst_dis_rdy", dis_rdy, 1'b1);
    chk("rst_iid", o_iid, 5'd0);
    chk("rst_pc", o_pc, 64'd0);
    chk("rst_s1", o_s1, 64'd0);
    chk("rst_imm", o_imm, 64'd0);
    @(negedge clk); rst_clk = 1'b1;

    // table: dispatch at N, issue at N+1, empty at N+2
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); idle();
      dis_vld = 1'b1; dis_iid = vt[k].iid; dis_opcode = vt[k].opc; dis_funct7 = vt[k].f7;
      dis_funct3 = vt[k].f3; dis_pc = vt[k].pc;
      dis_psrc1_vld = vt[k].s1v; dis_psrc1_rdy = vt[k].s1r; dis_psrc1_preg = vt[k].s1p; dis_psrc1_value = vt[k].s1val;
      dis_psrc2_vld = vt[k].s2v; dis_psrc2_rdy = vt[k].s2r; dis_psrc2_preg = vt[k].s2p; dis_psrc2_value = vt[k].s2val;
      dis_pdst_vld = vt[k].pdv; dis_pdst = vt[k].pd; dis_imm_vld = vt[k].imv; dis_imm = vt[k].imm;
      wb_vld = vt[k].wbv; wb_preg = vt[k].wbp; wb_data = vt[k].wbd;
      #1;
      chk($sformatf("v%0d_dis_rdy", k), dis_rdy, 1'b1);
      chk($sformatf("v%0d_no_iss_same_cyc", k), o_vld, 1'b0);
      @(negedge clk); idle(); #1;
      chk($sformatf("v%0d_vld", k), o_vld, 1'b1);
      chk($sformatf("v%0d_iid", k), o_iid, vt[k].iid);
      chk($sformatf("v%0d_opc", k), o_opc, vt[k].opc);
      chk($sformatf("v%0d_f7", k), o_f7, vt[k].f7);
      chk($sformatf("v%0d_f3", k), o_f3, vt[k].f3);
      chk($sformatf("v%0d_pc", k), o_pc, vt[k].pc);
      chk($sformatf("v%0d_s1v", k), o_s1v, vt[k].s1v);
      chk($sformatf("v%0d_s1", k), o_s1, vt[k].exp_s1);
      chk($sformatf("v%0d_s2v", k), o_s2v, vt[k].s2v);
      chk($sformatf("v%0d_s2", k), o_s2, vt[k].exp_s2);
      chk($sformatf("v%0d_pdst", k), {o_pdv, o_pd}, {vt[k].pdv, vt[k].pd});
      chk($sformatf("v%0d_imm", k), {o_imv, o_imm}, {vt[k].imv, vt[k].imm});
      @(negedge clk); #1;
      chk($sformatf("v%0d_empty_vld", k), o_vld, 1'b0);
      chk($sformatf("v%0d_empty_iid", k), o_iid, 5'd0);
      chk($sformatf("v%0d_empty_pc", k), o_pc, 64'd0);
    end

    // dependency: B waits on A's pdst 12, issues one cycle after wb
    @(negedge clk); idle(); disp(5'd1, 1'b1, 1'b1, 6'd1, 64'd3, 1'b1, 1'b1, 6'd2, 64'd4, 6'd12); #1;
    @(negedge clk); idle(); disp(5'd2, 1'b1, 1'b0, 6'd12, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 6'd13); #1;
    chk("dep_a_vld", o_vld, 1'b1);
    chk("dep_a_iid", o_iid, 5'd1);
    @(negedge clk); idle(); wb(6'd12, 64'h2A); #1;
    chk("dep_b_wait", o_vld, 1'b0);
    @(negedge clk); idle(); #1;
    chk("dep_b_vld", o_vld, 1'b1);
    chk("dep_b_iid", o_iid, 5'd2);
    chk("dep_b_s1", o_s1, 64'h2A);
    @(negedge clk); #1;
    chk("dep_empty", o_vld, 1'b0);

    // full queue: 8 waiting entries, tags 20..27
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); idle();
      disp(5'(10 + k), 1'b1, 1'b0, 6'(20 + k), 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 6'd1); #1;
      chk($sformatf("full_fill%0d_rdy", k), dis_rdy, 1'b1);
      chk($sformatf("full_fill%0d_vld", k), o_vld, 1'b0);
    end
    @(negedge clk); idle(); disp(5'd31, 1'b1, 1'b1, 6'd0, 64'd0, 1'b1, 1'b1, 6'd0, 64'd0, 6'd1); #1;
    chk("full_dis_rdy", dis_rdy, 1'b0);
    chk("full_vld", o_vld, 1'b0);
    @(negedge clk); idle(); wb(6'd25, 64'h55); #1;
    chk("full_ignored_rdy", dis_rdy, 1'b0);
    chk("full_ignored_vld", o_vld, 1'b0);
    @(negedge clk); idle(); #1;
    chk("full_s5_vld", o_vld, 1'b1);
    chk("full_s5_iid", o_iid, 5'd15);
    chk("full_s5_s1", o_s1, 64'h55);
    chk("full_no_credit", dis_rdy, 1'b0);
    @(negedge clk); idle(); wb(6'd20, 64'h60); #1;
    chk("full_after_rdy", dis_rdy, 1'b1);
    chk("full_after_vld", o_vld, 1'b0);
    // slot 0 issues while everything shifts; top entry wakes mid-shift
    @(negedge clk); idle(); wb(6'd27, 64'h70); #1;
    chk("order_s0_iid", o_iid, 5'd10);
    chk("order_s0_s1", o_s1, 64'h60);
    @(negedge clk); idle(); #1;
    chk("shift_wake_vld", o_vld, 1'b1);
    chk("shift_wake_iid", o_iid, 5'd17);
    chk("shift_wake_s1", o_s1, 64'h70);
    @(negedge clk); idle(); rtu_global_flush = 1'b1; #1;
    chk("full_flush_vld", o_vld, 1'b0);
    @(negedge clk); idle(); #1;
    chk("full_flush_rdy", dis_rdy, 1'b1);

    // two slots woken by one broadcast: oldest first
    @(negedge clk); idle(); disp(5'd1, 1'b1, 1'b0, 6'd40, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 6'd1);
    @(negedge clk); idle(); disp(5'd2, 1'b1, 1'b0, 6'd41, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 6'd2);
    @(negedge clk); idle(); disp(5'd3, 1'b1, 1'b0, 6'd40, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 6'd3);
    @(negedge clk); idle(); wb(6'd50, 64'hDEAD); #1;
    chk("two_pre_vld", o_vld, 1'b0);
    @(negedge clk); idle(); #1;
    chk("two_nomatch_vld", o_vld, 1'b0);
    @(negedge clk); idle(); wb(6'd40, 64'h77); #1;
    chk("two_wb_cyc_vld", o_vld, 1'b0);
    @(negedge clk); idle(); #1;
    chk("two_first_iid", o_iid, 5'd1);
    chk("two_first_s1", o_s1, 64'h77);
    @(negedge clk); idle(); #1;
    chk("two_second_vld", o_vld, 1'b1);
    chk("two_second_iid", o_iid, 5'd3);
    chk("two_second_s1", o_s1, 64'h77);
    @(negedge clk); idle(); #1;
    chk("two_rest_vld", o_vld, 1'b0);

    // flush with 4 ready entries and a dispatch in the same cycle
    // (queue still holds iid 2 waiting on 41)
    @(negedge clk); idle(); rtu_global_flush = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle();
      disp(5'(20 + k), 1'b1, 1'b0, 6'd30, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0, 6'd4);
    end
    @(negedge clk); idle(); wb(6'd30, 64'h31); #1;
    chk("fl_pre_vld", o_vld, 1'b0);
    @(negedge clk); idle(); rtu_global_flush = 1'b1;
    disp(5'd5, 1'b1, 1'b1, 6'd0, 64'd0, 1'b1, 1'b1, 6'd0, 64'd0, 6'd5); #1;
    chk("fl_cyc_vld", o_vld, 1'b0);
    chk("fl_cyc_iid", o_iid, 5'd0);
    @(negedge clk); idle(); #1;
    chk("fl_after_vld", o_vld, 1'b0);
    chk("fl_after_rdy", dis_rdy, 1'b1);
    @(negedge clk); idle(); disp(5'd6, 1'b1, 1'b1, 6'd0, 64'd9, 1'b0, 1'b0, 6'd0, 64'd0, 6'd6); #1;
    @(negedge clk); idle(); #1;
    chk("fl_restart_iid", o_iid, 5'd6);
    chk("fl_restart_s1", o_s1, 64'd9);

    // asynchronous reset with a ready entry pending
    @(negedge clk); idle(); disp(5'd9, 1'b1, 1'b1, 6'd0, 64'd1, 1'b0, 1'b0, 6'd0, 64'd0, 6'd7);
    @(negedge clk); idle(); #1;
    chk("ar_pre_vld", o_vld, 1'b1);
    rst_clk = 1'b0; #1;
    chk("ar_vld", o_vld, 1'b0);
    chk("ar_iid", o_iid, 5'd0);
    chk("ar_dis_rdy", dis_rdy, 1'b1);
    @(negedge clk); rst_clk = 1'b1; #1;
    chk("ar_post_vld", o_vld, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
